// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: bytes queued over valid/ready, sent LSB first as 8N1 frames.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit after data bit 7 (8E1 frames).
module uart_tx_fifo #(
    parameter int DELAY_FRAMES = 234,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(DELAY_FRAMES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DELAY_FRAMES - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic empty, full, push, pop, timer_last;
    logic [7:0] head;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = in_valid && !full;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign timer_last = (timer_q == TIMER_LAST);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q != IDLE && !timer_last) begin
            timer_d = timer_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                pop  = !empty;
            end
            START: begin
                if (timer_last) begin
                    timer_d = '0;
                    state_d = DATA;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (timer_last) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_d];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (timer_last) begin
                    timer_d = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (timer_last) begin
                    timer_d = '0;
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase
        // Popping the head always launches a start bit, whether from IDLE or straight out of STOP.
        if (pop) begin
            data_d  = head;
            bit_d   = 3'd0;
            timer_d = '0;
            state_d = START;
            tx_d    = 1'b0;
        end
    end

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    assign busy_d   = (state_d != IDLE) || (wr_ptr_d != rd_ptr_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bit_q    <= 3'd0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        data_q <= data_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    assign uart_tx    = tx_q;
    assign busy       = busy_q;
    assign in_ready   = !full;
    assign fifo_count = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (depth 16 and depth 4) checked every cycle against a
// frame-timeline model, plus directed literal checks and a line decoder.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int DF = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif
    localparam int FRAME   = NB * DF;
    localparam int DEPTH_A = 16;
    localparam int DEPTH_B = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid_a = 1'b0;
    logic       in_valid_b = 1'b0;
    logic       rdy_a, tx_a, busy_a, rdy_b, tx_b, busy_b;
    logic [4:0] cnt_a;
    logic [2:0] cnt_b;

    uart_tx_fifo #(.DELAY_FRAMES(DF), .FIFO_DEPTH(DEPTH_A)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_a),
        .in_ready(rdy_a), .uart_tx(tx_a), .busy(busy_a), .fifo_count(cnt_a)
    );
    uart_tx_fifo #(.DELAY_FRAMES(DF), .FIFO_DEPTH(DEPTH_B)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid_b),
        .in_ready(rdy_b), .uart_tx(tx_b), .busy(busy_b), .fifo_count(cnt_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expected line level for bit-time i of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (PAR && i == 9) return ^b;
        return 1'b1;
    endfunction

    // Model state: log of accepted bytes, frame-in-flight and its elapsed cycles.
    logic [7:0] m_log [2][512];
    int         m_wr [2];
    int         m_rd [2];
    int         m_t [2];
    bit         m_act [2];
    logic [7:0] m_cur [2];

    // Line decoder results.
    bit         d_act [2];
    int         d_start [2];
    logic [7:0] d_byte [2];
    logic       d_par [2];
    int         dec_n [2];
    logic [7:0] dec_bytes [2][64];
    int         dec_starts [2][64];
    logic       dec_pars [2][64];

    initial begin
        logic       s_rst;
        logic [1:0] s_vld;
        logic [7:0] s_data;
        int         cnt, depth, off, bi;
        logic       tx, bz, rd;
        int         fc;
        string      nm;
        for (int d = 0; d < 2; d++) begin
            m_wr[d] = 0; m_rd[d] = 0; m_t[d] = 0; m_act[d] = 1'b0; m_cur[d] = 8'h00;
            d_act[d] = 1'b0; d_start[d] = 0; d_byte[d] = 8'h00; d_par[d] = 1'b0; dec_n[d] = 0;
        end
        forever begin
            @(posedge clk);
            s_rst  = rst;
            s_vld  = {in_valid_b, in_valid_a};
            s_data = in_data;
            cyc++;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                depth = (d == 0) ? DEPTH_A : DEPTH_B;
                nm    = (d == 0) ? "a" : "b";
                cnt   = m_wr[d] - m_rd[d];
                if (s_rst) begin
                    m_rd[d] = m_wr[d]; m_act[d] = 1'b0; m_t[d] = 0;
                end else begin
                    if (m_act[d]) begin
                        m_t[d]++;
                        if (m_t[d] == FRAME) begin
                            m_t[d] = 0;
                            if (cnt > 0) begin
                                m_cur[d] = m_log[d][m_rd[d]]; m_rd[d]++;
                            end else begin
                                m_act[d] = 1'b0;
                            end
                        end
                    end else if (cnt > 0) begin
                        m_cur[d] = m_log[d][m_rd[d]]; m_rd[d]++; m_act[d] = 1'b1; m_t[d] = 0;
                    end
                    if (s_vld[d] && cnt < depth) begin
                        m_log[d][m_wr[d]] = s_data; m_wr[d]++;
                    end
                end
                cnt = m_wr[d] - m_rd[d];
                tx  = (d == 0) ? tx_a : tx_b;
                bz  = (d == 0) ? busy_a : busy_b;
                rd  = (d == 0) ? rdy_a : rdy_b;
                fc  = (d == 0) ? int'(cnt_a) : int'(cnt_b);
                chk({"uart_tx_", nm}, tx, m_act[d] ? frame_bit(m_cur[d], m_t[d] / DF) : 1'b1);
                chk({"busy_", nm}, bz, (m_act[d] || cnt > 0) ? 1 : 0);
                chk({"fifo_count_", nm}, fc, cnt);
                chk({"in_ready_", nm}, rd, (cnt < depth) ? 1 : 0);

                if (s_rst) begin
                    d_act[d] = 1'b0;
                end else if (!d_act[d]) begin
                    if (tx == 1'b0) begin
                        d_act[d] = 1'b1; d_start[d] = cyc;
                    end
                end else begin
                    off = cyc - d_start[d];
                    if (off % DF == DF / 2) begin
                        bi = off / DF;
                        if (bi >= 1 && bi <= 8) begin
                            d_byte[d][bi-1] = tx;
                        end else if (PAR && bi == 9) begin
                            d_par[d] = tx;
                        end else if (bi == NB - 1) begin
                            chk({"stop_bit_", nm}, tx, 1);
                            dec_bytes[d][dec_n[d]]  = d_byte[d];
                            dec_starts[d][dec_n[d]] = d_start[d];
                            dec_pars[d][dec_n[d]]   = d_par[d];
                            dec_n[d]++;
                            d_act[d] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input int n, output int peak, output int lows);
        peak = 0;
        lows = 0;
        repeat (n) begin
            step(1);
            if (int'(cnt_a) > peak) peak = int'(cnt_a);
            if (tx_a == 1'b0) lows++;
        end
    endtask

    initial begin
        logic [10:0] lit;
        logic [7:0]  bytes4 [6];
        string       s;
        int          n0, base_a, base_b, peak, lows;

        step(3);
        rst = 1'b0;
        chk("rst_tx_a", tx_a, 1);      chk("rst_tx_b", tx_b, 1);
        chk("rst_ready_a", rdy_a, 1);  chk("rst_ready_b", rdy_b, 1);
        chk("rst_busy_a", busy_a, 0);  chk("rst_busy_b", busy_b, 0);
        chk("rst_count_a", cnt_a, 0);  chk("rst_count_b", cnt_b, 0);

        // Single byte 0x4C: {stop, [parity,] data, start} read LSB first as bit-times.
        lit = PAR ? 11'b1_1_01001100_0 : 11'b0_1_01001100_0;
        in_data = 8'h4C; in_valid_a = 1'b1;
        step(1);
        in_valid_a = 1'b0;
        n0 = cyc;
        chk("c4_count_after_push", cnt_a, 1);
        chk("c4_busy_after_push", busy_a, 1);
        chk("c4_tx_idle_at_push", tx_a, 1);
        for (int k = 0; k < FRAME; k++) begin
            step(1);
            chk("c4_frame_bit", tx_a, lit[k / DF]);
            if (k == 0) chk("c4_count_after_pop", cnt_a, 0);
        end
        chk("c4_busy_last_stop", busy_a, 1);
        step(1);
        chk("c4_busy_low_end", busy_a, 0);
        chk("c4_end_cycle", cyc - n0, FRAME + 1);
        step(5);

        // "Lushay" to both instances in consecutive cycles.
        s = "Lushay";
        base_a = dec_n[0];
        base_b = dec_n[1];
        for (int i = 0; i < 6; i++) begin
            in_data = s[i]; in_valid_a = 1'b1; in_valid_b = 1'b1;
            step(1);
            if (i == 1) chk("lushay_pop_push_count_a", cnt_a, 1);
            if (i == 4) begin
                chk("full_ready_b", rdy_b, 0);
                chk("full_count_b", cnt_b, 4);
            end
            if (i == 5) chk("drop_count_b", cnt_b, 4);
        end
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        run(6 * FRAME + 10, peak, lows);
        chk("lushay_peak_a", peak, 5);
        chk("lushay_frames_a", dec_n[0] - base_a, 6);
        chk("full_frames_b", dec_n[1] - base_b, 5);
        for (int i = 0; i < 6; i++) begin
            chk("lushay_byte_a", dec_bytes[0][base_a + i], s[i]);
            if (i > 0) chk("lushay_spacing_a", dec_starts[0][base_a + i] - dec_starts[0][base_a + i - 1], FRAME);
            if (i < 5) chk("full_byte_b", dec_bytes[1][base_b + i], s[i]);
        end

        // Depth-4 instance full while a pop is due; 0x55 presented across the pop edge.
        bytes4 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h55};
        base_b = dec_n[1];
        for (int i = 0; i < 5; i++) begin
            in_data = bytes4[i]; in_valid_b = 1'b1;
            step(1);
            if (i == 0) n0 = cyc;
        end
        in_valid_b = 1'b0;
        chk("pf_full_ready_b", rdy_b, 0);
        step(n0 + FRAME - cyc);
        in_data = 8'h55; in_valid_b = 1'b1;
        step(1);
        chk("pf_pop_edge_count_b", cnt_b, 3);
        chk("pf_pop_edge_ready_b", rdy_b, 1);
        step(1);
        in_valid_b = 1'b0;
        chk("pf_accept_count_b", cnt_b, 4);
        chk("pf_accept_ready_b", rdy_b, 0);
        run(6 * FRAME + 10, peak, lows);
        chk("pf_frames_b", dec_n[1] - base_b, 6);
        for (int i = 0; i < 6; i++) chk("pf_byte_b", dec_bytes[1][base_b + i], bytes4[i]);

        // Reset during data bit 3 of 0xA5 with two bytes queued.
        base_a = dec_n[0];
        in_data = 8'hA5; in_valid_a = 1'b1;
        step(1);
        n0 = cyc;
        in_data = 8'h11;
        step(1);
        in_data = 8'h22;
        step(1);
        in_valid_a = 1'b0;
        chk("rst_mid_queued_a", cnt_a, 2);
        step(n0 + 1 + 4 * DF - cyc);
        chk("rst_mid_bit3_a", tx_a, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_mid_tx_a", tx_a, 1);
        chk("rst_mid_count_a", cnt_a, 0);
        chk("rst_mid_busy_a", busy_a, 0);
        chk("rst_mid_ready_a", rdy_a, 1);
        run(3 * FRAME, peak, lows);
        chk("rst_mid_no_low_a", lows, 0);
        chk("rst_mid_no_frames_a", dec_n[0] - base_a, 0);
        chk("rst_mid_busy_later_a", busy_a, 0);

`ifdef UART_TX_PARITY_EN
        base_a = dec_n[0];
        in_data = 8'h07; in_valid_a = 1'b1;
        step(1);
        in_data = 8'h03;
        step(1);
        in_valid_a = 1'b0;
        run(3 * FRAME, peak, lows);
        chk("par_frames_a", dec_n[0] - base_a, 2);
        chk("par_byte0_a", dec_bytes[0][base_a], 8'h07);
        chk("par_byte1_a", dec_bytes[0][base_a + 1], 8'h03);
        chk("par_bit0_a", dec_pars[0][base_a], 1);
        chk("par_bit1_a", dec_pars[0][base_a + 1], 0);
        chk("par_spacing_a", dec_starts[0][base_a + 1] - dec_starts[0][base_a], 44);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
